// File: rtl/fetch_queue_reader.sv
// Consumer end of the instruction FIFO: pops words into a 2-entry buffer and tags each with its PC for decode.
// Latency 1 cycle FIFO head to instr_valid; pops depend only on local occupancy, never on instr_ready.
module fetch_queue_reader #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    input  logic [WORD_SIZE-1:0] fifo_rdata,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 fifo_clr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [31:0]          instr_pc,
    output logic [31:0]          accept_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [1:0]           occ_q;
    logic [WORD_SIZE-1:0] word0_q, word1_q;
    logic [31:0]          pc0_q, pc1_q;
    logic [31:0]          fetch_pc_q;
    logic                 pop, accept;
    logic [1:0]           tail;

    always_comb begin
        state_d  = state_q;
        fifo_clr = 1'b0;
        if (state_q == FLUSH) begin
            fifo_clr = 1'b1;
            state_d  = RUN;
        end
        if (flush) begin
            state_d = FLUSH;
        end
    end

    // rst gates the pop so nothing is consumed from the FIFO while the reader is held in reset
    assign pop         = en && !flush && (state_q == RUN) && !fifo_empty && (occ_q < 2'd2) && !rst;
    assign fifo_rd_en  = pop;
    assign instr_valid = (occ_q != 2'd0);
    assign accept      = instr_valid && instr_ready && !flush;
    assign tail        = occ_q - {1'b0, accept};
    assign instr_data  = word0_q;
    assign instr_pc    = pc0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q        <= 2'd0;
            fetch_pc_q   <= RESET_PC;
            accept_count <= 32'd0;
            word0_q      <= '0;
            word1_q      <= '0;
            pc0_q        <= 32'd0;
            pc1_q        <= 32'd0;
        end else if (flush) begin
            occ_q      <= 2'd0;
            fetch_pc_q <= flush_pc;
        end else begin
            occ_q <= occ_q - {1'b0, accept} + {1'b0, pop};
            if (accept) begin
                word0_q      <= word1_q;
                pc0_q        <= pc1_q;
                accept_count <= accept_count + 32'd1;
            end
            // the tail slot is computed after any same-cycle accept, so a pop lands behind the survivor
            if (pop) begin
                if (tail == 2'd0) begin
                    word0_q <= fifo_rdata;
                    pc0_q   <= fetch_pc_q;
                end else begin
                    word1_q <= fifo_rdata;
                    pc1_q   <= fetch_pc_q;
                end
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

endmodule

// File: doc/fetch_queue_reader.md
Name: fetch_queue_reader

Overview:
- Consumer end of the 32-bit instruction FIFO. Pops words from the FIFO head and holds them in a 2-entry output buffer.
- Tags each word with its PC and presents it to decode over a valid/ready handshake.
- Handles pipeline flush: drops buffered words, reloads the PC and pulses a clear to the FIFO.
- Sits between the fetch FIFO and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC tag given to the first word after reset.
- WORD_SIZE, 32, instruction/data width; must match the FIFO word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  when 1, the reader may pop the FIFO; when 0, pops stop and the buffer is held.
- flush  input  1  single-cycle flush request.
- flush_pc  input  32  PC of the first word after a flush; sampled when flush=1.
- fifo_rdata  input  WORD_SIZE  FIFO head word; valid combinationally whenever fifo_empty=0 (show-ahead).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop strobe; the FIFO advances at the edge where this is 1.
- fifo_clr  output  1  one-cycle clear pulse to the FIFO after a flush.
- instr_valid  output  1  buffer head holds a word.
- instr_ready  input  1  decode accepts the head word this cycle.
- instr_data  output  WORD_SIZE  buffer head word.
- instr_pc  output  32  PC tag of the buffer head.
- accept_count  output  32  number of completed instr_valid&&instr_ready handshakes; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, immediate):
  - occupancy=0, state=RUN, fetch_pc=RESET_PC, accept_count=0.
  - fifo_clr=0, instr_valid=0, instr_data=0, instr_pc=0.
  - Asserting reset mid-operation discards all buffered words; no handshake completes in that cycle.
- Buffer:
  - 2 entries of {word, pc}; occupancy 0..2.
  - instr_valid = (occupancy != 0); instr_data and instr_pc come from the oldest entry.
- Pop rule (combinational):
  - fifo_rd_en = en && !flush && state==RUN && !fifo_empty && occupancy<2.
  - fifo_rd_en has no dependence on instr_ready, so no combinational path exists from decode to the FIFO.
- On a pop edge:
  - {fifo_rdata, fetch_pc} is written at the buffer tail.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- Accept:
  - instr_valid && instr_ready removes the head entry at the edge.
  - accept_count increments.
- Simultaneous pop and accept:
  - Occupancy is unchanged; the new word enters behind the remaining entry.
  - With occupancy 1 and a pop every cycle, throughput is one word per cycle.
- Latency: a word at the FIFO head while occupancy is 0 is popped at edge N and appears on instr_valid/instr_data in the cycle after edge N. Latency is 1 cycle.
- States:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle.
    - fifo_clr=1 and fifo_rd_en=0 throughout.
    - Returns to RUN at the next edge.
- Flush (flush=1 at edge E, in any state):
  - occupancy <= 0; fetch_pc <= flush_pc; state <= FLUSH.
  - Words are discarded even if instr_ready=1 in that cycle: no handshake counts and accept_count is unchanged.
  - instr_valid is 0 from the cycle after E.
  - The first pop is possible in the cycle after the FLUSH cycle.
- Flush asserted during FLUSH:
  - flush_pc is reloaded and the FLUSH cycle restarts.
  - fifo_clr stays high for one more cycle.
- en=0:
  - No pops occur.
  - Buffered words remain deliverable and accepts still complete.
- Empty FIFO: fifo_rd_en is never 1 while fifo_empty=1.
- Full buffer (occupancy 2): no pop occurs even if instr_ready=1 in the same cycle. Draining and refilling alternate; this is intentional and keeps timing simple.
- Stability: instr_data and instr_pc are stable while instr_valid=1 and instr_ready=0.

Test Plan:
- Reset, FIFO holds 3 words A,B,C, en=1, instr_ready=1 -> instr_valid from the cycle after the first pop. Words delivered A,B,C with PCs 0x0,0x4,0x8 on consecutive cycles. accept_count=3.
- instr_ready=0 with 4 words queued -> exactly 2 pops, occupancy 2. fifo_rd_en=0 thereafter. instr_data=A held stable. Release ready -> A,B,C,D delivered in order with no loss or duplication.
- Flush with flush_pc=0x100 while occupancy=2 and instr_ready=1 -> no accept counted. instr_valid=0 the next cycle. fifo_clr high for exactly 1 cycle. Next popped word tagged 0x100, the following one 0x104.
- RESET_PC=32'hFFFF_FFFC, deliver 2 words -> PCs 0xFFFF_FFFC then 0x0000_0000.
- en toggled 0 for 5 cycles with the FIFO non-empty -> fifo_rd_en=0 during those cycles. Buffered words still accepted. Popping resumes the cycle en returns to 1.
- Asynchronous rst asserted mid-cycle with occupancy 2 -> instr_valid drops immediately without a clock edge. accept_count=0. fifo_rd_en=0 while rst is high.
